psum_route_node: RTL
====================

# psum_route_node

Parametrised partial-sum chain node, the next generation of the processing-element router. It pairs words from the local accumulator FIFO with partial sums arriving from the upstream node, adds them in a fixed-latency integer pipeline, tags each result with the node ID, and routes it either to the previous chain node or to the output mux. A global stall enable is replaced by ready/valid handshakes, an input skid FIFO, and a credit-checked output FIFO, so the adder pipeline never stalls.

## Interface

- DATA_W, 32, psum/accumulator data width (two's complement)
- ID_W, 8, node ID tag width
- ADD_LAT, 7, adder pipeline depth in cycles (≥1)
- IN_DEPTH, 4, psum input skid FIFO depth (power of 2, ≥2)
- OUT_DEPTH, 16, output FIFO depth (power of 2); full throughput requires ≥ ADD_LAT+2
- SATURATE, 1, 1 = clamp sum to signed range, 0 = wrap
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- conf_enable  in  1  node enable; static except for the drain rule below
- conf_psum_input  in  1  1 = add upstream psum, 0 = pass local data through
- conf_psum_output  in  1  1 = route results to omux, 0 = route to previous node
- conf_id  in  ID_W  tag placed in psum_o upper bits
- psum_i  in  DATA_W  upstream partial sum
- psum_valid_i  in  1  upstream valid
- psum_ready_o  in/out: out  1  skid FIFO can accept a word
- fifo_empty_i  in  1  local accumulator FIFO empty
- fifo_rdreq_o  out  1  local FIFO read; data returns one cycle later
- fifo_rddata_i  in  DATA_W  local FIFO read data
- psum_o  out  ID_W+DATA_W  {conf_id, result}
- psum_to_prev_valid_o  out  1  result valid toward previous node
- psum_to_omux_valid_o  out  1  result valid toward output mux
- prev_ready_i  in  1  previous node accepts
- omux_ready_i  in  1  output mux accepts
- busy_o  out  1  any word in skid FIFO, pipeline, or output FIFO
- err_o  out  1  sticky protocol error

## Operation

- Skid FIFO:
  - psum_ready_o = conf_enable & conf_psum_input & !skid_full.
  - psum_valid_i & psum_ready_o pushes psum_i.
  - psum_valid_i while psum_ready_o=0 drops the word and sets err_o. err_o clears only on reset.
- Issue condition: conf_enable & !fifo_empty_i & (!conf_psum_input | skid_nonempty) & (inflight + out_count < OUT_DEPTH).
- On issue, in the same cycle:
  - assert fifo_rdreq_o;
  - pop the skid head into an alignment register (add mode only);
  - increment inflight.
- Cycle after issue:
  - Add mode: feed fifo_rddata_i and the aligned psum into the adder.
  - Pass mode: write fifo_rddata_i straight to the output FIFO.
- Adder: signed DATA_W+1 internal sum. With SATURATE=1 the sum clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; otherwise it wraps to DATA_W. No clock enable; a valid bit travels with the data.
- Output FIFO write decrements inflight.
  - Simultaneous issue and write leave inflight unchanged.
  - Simultaneous push and pop leave out_count unchanged.
- Output:
  - The output FIFO is first-word-fallthrough.
  - Head valid is steered to psum_to_omux_valid_o if conf_psum_output, else to psum_to_prev_valid_o. The non-selected valid is 0.
  - Pop on selected valid & selected ready. The non-selected ready is ignored.
- Drain rule: on conf_enable falling, issue stops and psum_ready_o drops. In-flight words finish and the output FIFO keeps draining. Skid contents are retained. Config other than conf_enable may change only when busy_o=0.
- Ordering: results leave in issue order. The credit check guarantees the output FIFO never overflows.

## Timing

- Reset values:
  - all valids, fifo_rdreq_o, psum_ready_o, busy_o, err_o = 0;
  - psum_o data field = 0;
  - all FIFOs empty; inflight = 0.
- Latency from issue cycle to selected valid high:
  - add mode: ADD_LAT+2;
  - pass mode: 2.
- Throughput is one result per cycle when the source and sink are always ready and OUT_DEPTH ≥ ADD_LAT+2.
- psum_ready_o depends only on registered state plus config. It has no combinational path from psum_valid_i.
- fifo_rdreq_o is combinational from fifo_empty_i, skid state, credits, and config. It has no path from the ready inputs.
- Reset asserted mid-operation discards all in-flight data immediately.

## Test plan

- Pass mode, omux route, ID=0x2A: local FIFO holds 5, 7, −3 with omux_ready_i=1.
  - psum_o = {0x2A, 5}, {0x2A, 7}, {0x2A, −3} on consecutive cycles.
  - First valid 2 cycles after the first rdreq; psum_to_prev_valid_o stays 0.
- Add mode, prev route, ADD_LAT=7: local 10, 20 plus upstream 1, 2.
  - Results 11 and 22 on psum_to_prev_valid_o.
  - First result 9 cycles after issue.
- Saturation, DATA_W=32: 0x7FFFFFF0 + 0x20 → 0x7FFFFFFF; 0x80000000 + (−1) → 0x80000000.
  - With SATURATE=0 the results are 0x80000010 and 0x7FFFFFFF.
- Backpressure: hold prev_ready_i=0 for 40 cycles with continuous input.
  - Issue stops with exactly OUT_DEPTH words buffered.
  - No loss, order preserved after release.
  - psum_ready_o drops once the skid FIFO fills.
- Protocol error: fill the skid FIFO with local FIFO empty, then push once more.
  - err_o rises the next cycle and stays high.
  - Skid contents are unchanged.
- Enable drop: deassert conf_enable with 3 words in flight.
  - All 3 are delivered and busy_o falls.
  - A reset pulse mid-stream clears all outputs to their reset values within the same cycle.

Source files
------------

// File: rtl/psum_route_node.sv
// psum_route_node: partial-sum chain node. Pairs local accumulator words with
// upstream partial sums, adds them in a fixed-latency pipeline that never
// stalls, tags results with the node ID and routes them to the previous node
// or the output mux. A credit check on the output FIFO guarantees that every
// issued word has a free slot waiting for it.
module psum_route_node #(
    parameter int DATA_W    = 32,
    parameter int ID_W      = 8,
    parameter int ADD_LAT   = 7,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 16,
    parameter int SATURATE  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   conf_enable,
    input  logic                   conf_psum_input,
    input  logic                   conf_psum_output,
    input  logic [ID_W-1:0]        conf_id,
    input  logic [DATA_W-1:0]      psum_i,
    input  logic                   psum_valid_i,
    output logic                   psum_ready_o,
    input  logic                   fifo_empty_i,
    output logic                   fifo_rdreq_o,
    input  logic [DATA_W-1:0]      fifo_rddata_i,
    output logic [ID_W+DATA_W-1:0] psum_o,
    output logic                   psum_to_prev_valid_o,
    output logic                   psum_to_omux_valid_o,
    input  logic                   prev_ready_i,
    input  logic                   omux_ready_i,
    output logic                   busy_o,
    output logic                   err_o
);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int CNT_W  = OUT_AW + 1;
    localparam int CRED_W = OUT_AW + 2;

    // Signed add on a DATA_W+1 bit sum; clamps on overflow when SATURATE is set.
    function automatic logic [DATA_W-1:0] add_clamp(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if ((SATURATE != 0) && (s[DATA_W] != s[DATA_W-1])) begin
            if (s[DATA_W]) begin
                return {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                return {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

    logic                  live;
    logic [DATA_W-1:0]     skid_mem [IN_DEPTH];
    logic [IN_AW-1:0]      skid_wr, skid_rd;
    logic [IN_AW:0]        skid_cnt;
    logic                  skid_full, skid_push, skid_pop;
    logic                  issue, issue_d, credit_ok;
    logic [DATA_W-1:0]     align;
    logic                  add_in_valid;
    logic [DATA_W-1:0]     add_sum;
    logic [DATA_W-1:0]     pipe_data [ADD_LAT];
    logic [ADD_LAT-1:0]    pipe_valid;
    logic [CNT_W-1:0]      inflight;
    logic [DATA_W-1:0]     out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0]     out_wr, out_rd;
    logic [CNT_W-1:0]      out_cnt;
    logic                  out_wr_en, out_pop, head_valid, sel_ready;
    logic [DATA_W-1:0]     out_wdata;

    // The live flag is cleared asynchronously by reset so that issue and
    // psum_ready drop in the same cycle reset rises, with no combinational
    // path from reset to the outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    assign skid_full    = (skid_cnt == (IN_AW+1)'(IN_DEPTH));
    assign psum_ready_o = live & conf_enable & conf_psum_input & ~skid_full;
    assign skid_push    = psum_valid_i & psum_ready_o;
    assign credit_ok    = ((CRED_W'(inflight) + CRED_W'(out_cnt)) < CRED_W'(OUT_DEPTH));
    assign issue        = live & conf_enable & ~fifo_empty_i & credit_ok &
                          (~conf_psum_input | (skid_cnt != '0));
    assign skid_pop     = issue & conf_psum_input;
    assign fifo_rdreq_o = issue;

    // Skid FIFO storage; contents are meaningful only below skid_cnt.
    always_ff @(posedge clock) begin
        if (skid_push) begin
            skid_mem[skid_wr] <= psum_i;
        end
    end

    // Skid FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skid_wr  <= '0;
            skid_rd  <= '0;
            skid_cnt <= '0;
        end else begin
            if (skid_push) skid_wr <= skid_wr + IN_AW'(1);
            if (skid_pop)  skid_rd <= skid_rd + IN_AW'(1);
            case ({skid_push, skid_pop})
                2'b10:   skid_cnt <= skid_cnt + (IN_AW+1)'(1);
                2'b01:   skid_cnt <= skid_cnt - (IN_AW+1)'(1);
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    // Sticky error: an upstream word offered while not ready is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_o <= 1'b0;
        end else if (psum_valid_i & ~psum_ready_o) begin
            err_o <= 1'b1;
        end
    end

    // Align the popped psum with local read data, which returns one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_d <= 1'b0;
            align   <= '0;
        end else begin
            issue_d <= issue;
            if (skid_pop) align <= skid_mem[skid_rd];
        end
    end

    assign add_in_valid = issue_d & conf_psum_input;
    assign add_sum      = add_clamp(fifo_rddata_i, align);

    // Adder pipeline valid bits; the pipeline has no enable and never stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= add_in_valid;
            for (int i = 1; i < ADD_LAT; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
    end

    // Adder pipeline data, travelling alongside the valid bits.
    always_ff @(posedge clock) begin
        pipe_data[0] <= add_sum;
        for (int i = 1; i < ADD_LAT; i++) pipe_data[i] <= pipe_data[i-1];
    end

    assign out_wr_en = pipe_valid[ADD_LAT-1] | (issue_d & ~conf_psum_input);
    assign out_wdata = pipe_valid[ADD_LAT-1] ? pipe_data[ADD_LAT-1] : fifo_rddata_i;

    // Words issued but not yet written into the output FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({issue, out_wr_en})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign head_valid = (out_cnt != '0);
    assign sel_ready  = conf_psum_output ? omux_ready_i : prev_ready_i;
    assign out_pop    = head_valid & sel_ready;

    // Output FIFO storage; never overflows thanks to the issue credit check.
    always_ff @(posedge clock) begin
        if (out_wr_en) begin
            out_mem[out_wr] <= out_wdata;
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_wr  <= '0;
            out_rd  <= '0;
            out_cnt <= '0;
        end else begin
            if (out_wr_en) out_wr <= out_wr + OUT_AW'(1);
            if (out_pop)   out_rd <= out_rd + OUT_AW'(1);
            case ({out_wr_en, out_pop})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign psum_o               = {conf_id, head_valid ? out_mem[out_rd] : {DATA_W{1'b0}}};
    assign psum_to_omux_valid_o = head_valid & conf_psum_output;
    assign psum_to_prev_valid_o = head_valid & ~conf_psum_output;
    assign busy_o               = (skid_cnt != '0) | (inflight != '0) | head_valid;
endmodule
